pixel_line_doubler: RTL and testbench

//  GPU-side consumer of the pixel framebuffer read port, clkPixel domain. Upscales the
//  320x240 R3G3B2 framebuffer to 640x480: each source pixel is shown twice horizontally.

---
 rtl/pixel_line_doubler_pkg.sv | 36 +++
 rtl/px_line_ram.sv | 27 ++
 rtl/pixel_line_doubler.sv | 153 +++++++++++++++
 tb/tb_pixel_line_doubler.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_line_doubler_pkg.sv
// Shared definitions for the pixel line doubler.
//   state_t    : row FSM encoding (S_BLANK / S_FETCH / S_REPLAY)
//   tap_t      : one stage of the x/active/mode delay line
//   H_ACT/V_ACT: active display area in output pixels
//   SRC_W/SRC_H: source framebuffer geometry
//   crc8_step  : one byte of CRC-8 (poly CRC8_POLY), used by the optional frame CRC
package pixel_line_doubler_pkg;

   typedef enum logic [1:0] {
      S_BLANK  = 2'd0,
      S_FETCH  = 2'd1,
      S_REPLAY = 2'd2
   } state_t;

   localparam logic [9:0] H_ACT     = 10'd640;
   localparam logic [9:0] V_ACT     = 10'd480;
   localparam int         SRC_W     = 320;
   localparam int         SRC_H     = 240;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   typedef struct packed {
      logic [9:0] x;
      logic       act;
      state_t     mode;
   } tap_t;

   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] d);
      logic [7:0] c;
      c = crc ^ d;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/px_line_ram.sv
// Line buffer: DEPTH x 8 simple dual-port RAM, one write port and one registered
// read port, written for block-RAM inference. Contents are not reset.
//   clk    : pixel clock
//   we     : write enable, waddr/wdata : write address/data
//   re     : read enable,  raddr       : read address
//   rdata  : read data, valid the cycle after re
module px_line_ram #(
   parameter int DEPTH = 320,
   parameter int AW    = 9
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/pixel_line_doubler.sv
// Pixel line doubler: shows a 320x240 R3G3B2 framebuffer as 640x480. Even rows are
// fetched from the framebuffer read port and copied into a line buffer; the following
// odd row is replayed from that buffer so the framebuffer is free for CPU writes.
// Optional feature macro: PX_LINE_DOUBLER_CRC_EN adds frame_crc (CRC-8 of the shown frame).
//   clkPixel          : pixel clock
//   reset_n           : asynchronous active-low reset
//   x, y, blank, vsync: timing generator inputs
//   gpu_addr/gpu_data : framebuffer read port (data arrives DATA_LAT cycles after address)
//   using_line_buffer : odd row served from the line buffer, framebuffer free
//   px_out, px_valid  : output pixel, DATA_LAT+2 cycles after x/y/blank
//   frame_crc         : (CRC build only) CRC of the previous frame, updated on vsync rise
//
// state    | meaning
// S_BLANK  | outside a row's active area, waiting for x==0
// S_FETCH  | row shown from framebuffer, even pixels copied into line buffer
// S_REPLAY | odd row shown from line buffer, gpu_addr frozen
module pixel_line_doubler #(
   parameter int DATA_LAT = 3,
   parameter int SRC_W    = pixel_line_doubler_pkg::SRC_W,
   parameter int SRC_H    = pixel_line_doubler_pkg::SRC_H
) (
   input  logic        clkPixel,
   input  logic        reset_n,
   input  logic [9:0]  x,
   input  logic [9:0]  y,
   input  logic        blank,
   input  logic        vsync,
   output logic [16:0] gpu_addr,
   input  logic [7:0]  gpu_data,
   output logic        using_line_buffer,
   output logic [7:0]  px_out,
   output logic        px_valid
`ifdef PX_LINE_DOUBLER_CRC_EN
   ,
   output logic [7:0]  frame_crc
`endif
);

   import pixel_line_doubler_pkg::*;

   localparam int AW   = $clog2(SRC_W);
   localparam int NTAP = DATA_LAT + 1;

   state_t     state, state_nxt;
   logic       line_ok;
   logic       active, row_start, frame_off;
   tap_t       tap_q [NTAP];
   tap_t       tap_out;
   logic       wr_en, rd_en;
   logic [7:0] rd_data;

   assign active    = !blank && (x < H_ACT) && (y < V_ACT);
   assign row_start = active && (x == 10'd0);
   assign frame_off = vsync || (y[9:1] >= 9'(SRC_H));

   always_comb begin
      state_nxt = state;
      if (row_start)    state_nxt = (y[0] && line_ok) ? S_REPLAY : S_FETCH;
      else if (!active) state_nxt = S_BLANK;
   end

   always_ff @(posedge clkPixel or negedge reset_n) begin
      if (!reset_n) state <= S_BLANK;
      else          state <= state_nxt;
   end

   // Delay line carries the mode that applies to each pixel (state_nxt, since the
   // state register itself only switches after the x==0 pixel).
   always_ff @(posedge clkPixel or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NTAP; i++) tap_q[i] <= '0;
      end else begin
         tap_q[0] <= '{x, active, state_nxt};
         for (int i = 1; i < NTAP; i++) tap_q[i] <= tap_q[i-1];
      end
   end

   assign tap_out = tap_q[NTAP-1];
   assign wr_en   = tap_out.act && (tap_out.mode == S_FETCH) && !tap_out.x[0];
   // Read one stage early so the registered read data lines up with tap_out.
   assign rd_en   = tap_q[NTAP-2].act && (tap_q[NTAP-2].mode == S_REPLAY);

   px_line_ram #(.DEPTH(SRC_W), .AW(AW)) u_line_ram (
      .clk   (clkPixel),
      .we    (wr_en),
      .waddr (tap_out.x[AW:1]),
      .wdata (gpu_data),
      .re    (rd_en),
      .raddr (tap_q[NTAP-2].x[AW:1]),
      .rdata (rd_data)
   );

   always_ff @(posedge clkPixel or negedge reset_n) begin
      if (!reset_n)
         gpu_addr <= '0;
      else if (active && state_nxt != S_REPLAY)
         gpu_addr <= 17'(y[9:1]) * 17'(SRC_W) + 17'(x[9:1]);
   end

   always_ff @(posedge clkPixel or negedge reset_n) begin
      if (!reset_n)
         line_ok <= 1'b0;
      else if (frame_off)
         line_ok <= 1'b0;
      else if (state == S_REPLAY && state_nxt == S_BLANK)
         line_ok <= 1'b0;
      else if (wr_en && tap_out.x == (H_ACT - 10'd2))
         line_ok <= 1'b1;
   end

   // Held from the replay decision until the next row's decision, so the
   // following hblank is also free for CPU writes.
   always_ff @(posedge clkPixel or negedge reset_n) begin
      if (!reset_n)       using_line_buffer <= 1'b0;
      else if (frame_off) using_line_buffer <= 1'b0;
      else if (row_start) using_line_buffer <= (state_nxt == S_REPLAY);
   end

   always_ff @(posedge clkPixel or negedge reset_n) begin
      if (!reset_n) begin
         px_out   <= '0;
         px_valid <= 1'b0;
      end else if (tap_out.act) begin
         px_out   <= (tap_out.mode == S_REPLAY) ? rd_data : gpu_data;
         px_valid <= 1'b1;
      end else begin
         px_out   <= '0;
         px_valid <= 1'b0;
      end
   end

`ifdef PX_LINE_DOUBLER_CRC_EN
   logic       vsync_q;
   logic [7:0] crc_run;

   always_ff @(posedge clkPixel or negedge reset_n) begin
      if (!reset_n) begin
         vsync_q   <= 1'b0;
         crc_run   <= '0;
         frame_crc <= '0;
      end else begin
         vsync_q <= vsync;
         if (vsync && !vsync_q) begin
            frame_crc <= crc_run;
            crc_run   <= '0;
         end else if (px_valid) begin
            crc_run <= crc8_step(crc_run, px_out);
         end
      end
   end
`endif

endmodule

// File: tb/tb_pixel_line_doubler.sv
module tb_pixel_line_doubler;

   localparam int H_TOT = 660;

   logic        clkPixel = 1'b0;
   logic        reset_n  = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic        blank = 1'b1;
   logic        vsync = 1'b0;
   logic [16:0] gpu_addr;
   logic [7:0]  gpu_data = '0;
   logic        using_line_buffer;
   logic [7:0]  px_out;
   logic        px_valid;
`ifdef PX_LINE_DOUBLER_CRC_EN
   logic [7:0]  frame_crc;
`endif

   pixel_line_doubler dut (
      .clkPixel          (clkPixel),
      .reset_n           (reset_n),
      .x                 (x),
      .y                 (y),
      .blank             (blank),
      .vsync             (vsync),
      .gpu_addr          (gpu_addr),
      .gpu_data          (gpu_data),
      .using_line_buffer (using_line_buffer),
      .px_out            (px_out),
      .px_valid          (px_valid)
`ifdef PX_LINE_DOUBLER_CRC_EN
      ,
      .frame_crc         (frame_crc)
`endif
   );

   always #20 clkPixel = ~clkPixel;

   // Framebuffer model: data appears 3 cycles after the address changes.
   logic [7:0] fb [76800];
   logic [7:0] d1 = '0, d2 = '0;
   always @(posedge clkPixel) begin
      d1       <= fb[gpu_addr];
      d2       <= d1;
      gpu_data <= d2;
   end

   int          n_checks = 0;
   int          n_fail   = 0;
   int          pend [5];
   logic [7:0]  cap_px   [640];
   logic        cap_val  [640];
   logic [16:0] cap_addr [640];
   logic [16:0] last_addr;
   int          addr_changes, stray, ulb_hi;
   logic        ulb_mid, ulb_hb;

   // One pixel clock: drive inputs, capture output belonging to the pixel driven
   // five clocks earlier (DATA_LAT+2).
   task automatic step(input int xi, input int yi, input logic bl, input logic vs);
      x = 10'(xi); y = 10'(yi); blank = bl; vsync = vs;
      @(posedge clkPixel);
      for (int i = 4; i > 0; i--) pend[i] = pend[i-1];
      pend[0] = (!bl && xi < 640 && yi < 480) ? xi : -1;
      @(negedge clkPixel);
      if (pend[0] >= 0) begin
         cap_addr[xi] = gpu_addr;
         if (gpu_addr !== last_addr) addr_changes++;
         last_addr = gpu_addr;
      end
      if (pend[4] >= 0) begin
         cap_px[pend[4]]  = px_out;
         cap_val[pend[4]] = px_valid;
      end else if (px_valid) begin
         stray++;
      end
      if (using_line_buffer) ulb_hi++;
      if (xi == 320) ulb_mid = using_line_buffer;
      if (xi == 650) ulb_hb  = using_line_buffer;
   endtask

   task automatic run_row(input int yi);
      for (int i = 0; i < 640; i++) begin
         cap_px[i] = '0; cap_val[i] = 1'b0; cap_addr[i] = '1;
      end
      addr_changes = 0;
      last_addr    = gpu_addr;
      for (int xi = 0; xi < H_TOT; xi++) step(xi, yi, xi >= 640, 1'b0);
   endtask

   task automatic vsync_pulse();
      for (int i = 0; i < 6; i++) step(700, 480, 1'b1, i < 3);
   endtask

   task automatic test_reset();
      logic [16:0] e;
      for (int xi = 100; xi < 120; xi++) step(xi, 1, 1'b0, 1'b0);
      n_checks++; if (gpu_addr !== 17'd0) begin n_fail++; $display("FAIL reset_addr got %0d want 0", gpu_addr); end
      n_checks++; if (px_out !== 8'd0) begin n_fail++; $display("FAIL reset_px got %0h want 0", px_out); end
      n_checks++; if (px_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", px_valid); end
      n_checks++; if (using_line_buffer !== 1'b0) begin n_fail++; $display("FAIL reset_ulb got %b want 0", using_line_buffer); end
      reset_n = 1'b1;
      for (int xi = 120; xi < H_TOT; xi++) step(xi, 1, xi >= 640, 1'b0);
      run_row(3);
      n_checks++; if (ulb_mid !== 1'b0) begin n_fail++; $display("FAIL first_odd_ulb got %b want 0", ulb_mid); end
      n_checks++; if (cap_addr[639] !== 17'd639) begin n_fail++; $display("FAIL first_odd_addr got %0d want 639", cap_addr[639]); end
      for (int xi = 0; xi < 640; xi++) begin
         e = 17'(320 + xi / 2);
         n_checks++;
         if (cap_val[xi] !== 1'b1 || cap_px[xi] !== e[7:0]) begin
            n_fail++; $display("FAIL first_odd_px x=%0d got %0h/%b want %0h/1", xi, cap_px[xi], cap_val[xi], e[7:0]);
         end
      end
   endtask

   task automatic test_fetch_row0();
      logic [16:0] e;
      run_row(0);
      n_checks++; if (ulb_mid !== 1'b0) begin n_fail++; $display("FAIL row0_ulb got %b want 0", ulb_mid); end
      for (int xi = 0; xi < 640; xi++) begin
         e = 17'(xi / 2);
         n_checks++;
         if (cap_addr[xi] !== e) begin n_fail++; $display("FAIL row0_addr x=%0d got %0d want %0d", xi, cap_addr[xi], e); end
         n_checks++;
         if (cap_val[xi] !== 1'b1 || cap_px[xi] !== e[7:0]) begin
            n_fail++; $display("FAIL row0_px x=%0d got %0h/%b want %0h/1", xi, cap_px[xi], cap_val[xi], e[7:0]);
         end
      end
   endtask

   task automatic test_replay_row1();
      logic [16:0] e;
      run_row(1);
      n_checks++; if (ulb_mid !== 1'b1) begin n_fail++; $display("FAIL row1_ulb_active got %b want 1", ulb_mid); end
      n_checks++; if (ulb_hb !== 1'b1) begin n_fail++; $display("FAIL row1_ulb_hblank got %b want 1", ulb_hb); end
      n_checks++; if (addr_changes !== 0) begin n_fail++; $display("FAIL row1_addr_held changes=%0d want 0", addr_changes); end
      for (int xi = 0; xi < 640; xi++) begin
         e = 17'(xi / 2);
         n_checks++;
         if (cap_val[xi] !== 1'b1 || cap_px[xi] !== e[7:0]) begin
            n_fail++; $display("FAIL row1_px x=%0d got %0h/%b want %0h/1", xi, cap_px[xi], cap_val[xi], e[7:0]);
         end
      end
   endtask

   task automatic test_vsync_clear();
      vsync_pulse();
      n_checks++; if (using_line_buffer !== 1'b0) begin n_fail++; $display("FAIL vsync_ulb got %b want 0", using_line_buffer); end
      run_row(1);
      n_checks++; if (ulb_mid !== 1'b0) begin n_fail++; $display("FAIL vsync_row1_ulb got %b want 0", ulb_mid); end
      n_checks++; if (cap_addr[0] !== 17'd0) begin n_fail++; $display("FAIL vsync_row1_addr0 got %0d want 0", cap_addr[0]); end
      n_checks++; if (cap_addr[639] !== 17'd319) begin n_fail++; $display("FAIL vsync_row1_addr639 got %0d want 319", cap_addr[639]); end
      n_checks++; if (cap_px[21] !== 8'd10) begin n_fail++; $display("FAIL vsync_row1_px21 got %0h want 0a", cap_px[21]); end
   endtask

   task automatic test_last_row();
      logic [16:0] e;
      run_row(478);
      n_checks++; if (cap_addr[639] !== 17'd76799) begin n_fail++; $display("FAIL row478_addr got %0d want 76799", cap_addr[639]); end
      n_checks++; if (cap_px[639] !== 8'hFF) begin n_fail++; $display("FAIL row478_last_px got %0h want ff", cap_px[639]); end
      run_row(479);
      e = 17'(239 * 320);
      n_checks++; if (ulb_mid !== 1'b1) begin n_fail++; $display("FAIL row479_ulb got %b want 1", ulb_mid); end
      n_checks++; if (cap_addr[639] !== 17'd76799) begin n_fail++; $display("FAIL row479_addr got %0d want 76799", cap_addr[639]); end
      n_checks++; if (cap_px[639] !== 8'hFF || cap_val[639] !== 1'b1) begin n_fail++; $display("FAIL row479_last_px got %0h/%b want ff/1", cap_px[639], cap_val[639]); end
      n_checks++; if (cap_px[0] !== e[7:0]) begin n_fail++; $display("FAIL row479_first_px got %0h want %0h", cap_px[0], e[7:0]); end
      ulb_hi = 0; stray = 0;
      for (int r = 480; r < 484; r++) begin
         for (int xi = 0; xi < H_TOT; xi++) step(xi, r, 1'b1, r == 482 && xi < 8);
      end
      n_checks++; if (ulb_hi !== 0) begin n_fail++; $display("FAIL vblank_ulb high_cycles=%0d want 0", ulb_hi); end
      n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL vblank_valid stray=%0d want 0", stray); end
   endtask

   task automatic test_corrupt();
      logic [16:0] e;
      run_row(2);
      n_checks++; if (cap_px[100] !== 8'h72) begin n_fail++; $display("FAIL row2_px100 got %0h want 72", cap_px[100]); end
      for (int a = 320; a < 960; a++) fb[a] = fb[a] ^ 8'hFF;
      run_row(3);
      n_checks++; if (ulb_mid !== 1'b1) begin n_fail++; $display("FAIL row3_ulb got %b want 1", ulb_mid); end
      for (int xi = 0; xi < 640; xi++) begin
         e = 17'(320 + xi / 2);
         n_checks++;
         if (cap_val[xi] !== 1'b1 || cap_px[xi] !== e[7:0]) begin
            n_fail++; $display("FAIL row3_replay_px x=%0d got %0h want %0h", xi, cap_px[xi], e[7:0]);
         end
      end
      run_row(4);
      n_checks++; if (ulb_mid !== 1'b0) begin n_fail++; $display("FAIL row4_ulb got %b want 0", ulb_mid); end
      for (int xi = 0; xi < 640; xi++) begin
         e = 17'(640 + xi / 2);
         n_checks++;
         if (cap_val[xi] !== 1'b1 || cap_px[xi] !== (e[7:0] ^ 8'hFF)) begin
            n_fail++; $display("FAIL row4_new_px x=%0d got %0h want %0h", xi, cap_px[xi], e[7:0] ^ 8'hFF);
         end
      end
   endtask

`ifdef PX_LINE_DOUBLER_CRC_EN
   function automatic logic [7:0] ref_crc8(input logic [7:0] c_in, input logic [7:0] d);
      logic [7:0] c;
      logic       fbk;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         fbk = c[7] ^ d[i];
         c   = {c[6:0], 1'b0};
         if (fbk) c = c ^ 8'h07;
      end
      return c;
   endfunction

   task automatic test_crc();
      logic [7:0] c;
      for (int a = 0; a < 320; a++) fb[a] = 8'h00;
      vsync_pulse();
      run_row(0); run_row(1);
      vsync_pulse();
      n_checks++; if (frame_crc !== 8'h00) begin n_fail++; $display("FAIL crc_zero got %0h want 00", frame_crc); end
      fb[5] = 8'h01;
      run_row(0); run_row(1);
      vsync_pulse();
      c = 8'h00;
      for (int r = 0; r < 2; r++)
         for (int xi = 0; xi < 640; xi++) c = ref_crc8(c, (xi / 2 == 5) ? 8'h01 : 8'h00);
      n_checks++; if (frame_crc !== c) begin n_fail++; $display("FAIL crc_one got %0h want %0h", frame_crc, c); end
   endtask
`endif

   initial begin
      logic [16:0] av;
      for (int i = 0; i < 5; i++) pend[i] = -1;
      for (int a = 0; a < 76800; a++) begin
         av = 17'(a);
         fb[a] = av[7:0];
      end
      addr_changes = 0; stray = 0; ulb_hi = 0;
      ulb_mid = 1'b0; ulb_hb = 1'b0; last_addr = '0;
      test_reset();
      test_fetch_row0();
      test_replay_row1();
      test_vsync_clear();
      test_last_row();
      test_corrupt();
`ifdef PX_LINE_DOUBLER_CRC_EN
      test_crc();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
